serial_subtractor: RTL and testbench

- Multi-cycle digit-serial subtractor: computes D = A - B - i_bin over WIDTH bits, LSB digit first, DIGIT bits per clock.
- Borrow-propagating counterpart of the combinational adder primitives; used for wide-word arithmetic (128-bit block/key words) where a full-width ripple path is too slow or too large.
- Valid/ready handshake on both input and output sides.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/half_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks.
//   state_e     : IDLE/RUN/DONE encoding used by the serial datapaths
//   num_digits  : digits per operation (N = width / digit)
//   cnt_width   : counter width for N digits, never narrower than 1 bit
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: i_bit1 - i_bit2.
//   i_bit1   : minuend bit
//   i_bit2   : subtrahend bit
//   o_diff   : difference bit
//   o_borrow : borrow out (set when i_bit1 < i_bit2)
module half_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  output logic o_diff,
  output logic o_borrow
);

  assign o_diff   = i_bit1 ^ i_bit2;
  assign o_borrow = ~i_bit1 & i_bit2;

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - bin over WIDTH bits, DIGIT bits per clock, LSB first.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_in_valid/o_in_ready : operand handshake (i_a, i_b, i_bin captured on accept)
//   i_out_ready/o_out_valid : result handshake
//   o_diff, o_bout, o_zero  : difference mod 2^WIDTH, final borrow, difference-is-zero
// Results are registered once per operation and held until the next one completes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_zero
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  // Borrow chain across the DIGIT bits handled this cycle.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_diff;

  assign chain[0] = borrow_q;

  for (genvar k = 0; k < DIGIT; k++) begin : g_bit
    logic d1, br1, br2;
    half_subtractor u_hs_ab (
      .i_bit1  (a_q[k]),
      .i_bit2  (b_q[k]),
      .o_diff  (d1),
      .o_borrow(br1)
    );
    half_subtractor u_hs_bin (
      .i_bit1  (d1),
      .i_bit2  (chain[k]),
      .o_diff  (digit_diff[k]),
      .o_borrow(br2)
    );
    assign chain[k+1] = br1 | br2;
  end

  // New digit enters at the MSB end; after N shifts the first digit sits at bit 0.
  logic [WIDTH+DIGIT-1:0] res_wide;
  logic [WIDTH-1:0]       res_shift;
  assign res_wide  = {digit_diff, res_q};
  assign res_shift = res_wide[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken on the first edge out of reset.
        if (in_ready_q && i_in_valid) begin
          a_d      = i_a;
          b_d      = i_b;
          borrow_d = i_bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = chain[DIGIT];
        res_d    = res_shift;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          diff_d  = res_shift;
          bout_d  = chain[DIGIT];
          zero_d  = (res_shift == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_diff      = diff_q;
  assign o_bout      = bout_q;
  assign o_zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c_results = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] d;
    logic         bo;
    logic         z;
    int           acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // Instance A: WIDTH=8, DIGIT=1
  logic       va = 1'b0, ra, ova, ora = 1'b1, bin_a = 1'b0, boa, za;
  logic [7:0] a_a = '0, b_a = '0, da;
  // Instance B: WIDTH=8, DIGIT=2
  logic       vb = 1'b0, rb, ovb, orb = 1'b1, bin_b = 1'b0, bob, zb;
  logic [7:0] a_b = '0, b_b = '0, db;
  // Instance C: WIDTH=128, DIGIT=1
  logic         vc = 1'b0, rc, ovc, orc = 1'b1, bin_c = 1'b0, boc, zc;
  logic [127:0] a_c = '0, b_c = '0, dc;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_in_valid(va), .o_in_ready(ra), .i_a(a_a), .i_b(b_a),
    .i_bin(bin_a), .o_out_valid(ova), .i_out_ready(ora), .o_diff(da), .o_bout(boa), .o_zero(za)
  );
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_in_valid(vb), .o_in_ready(rb), .i_a(a_b), .i_b(b_b),
    .i_bin(bin_b), .o_out_valid(ovb), .i_out_ready(orb), .o_diff(db), .o_bout(bob), .o_zero(zb)
  );
  serial_subtractor #(.WIDTH(128), .DIGIT(1)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_in_valid(vc), .o_in_ready(rc), .i_a(a_c), .i_b(b_c),
    .i_bin(bin_c), .o_out_valid(ovc), .i_out_ready(orc), .o_diff(dc), .o_bout(boc), .o_zero(zc)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic cmp_res(input string tag, input logic [127:0] d, input logic bo, input logic z,
                         input exp_t e, input int n);
    chk({tag, "_diff"}, d, e.d);
    chk({tag, "_bout"}, 128'(bo), 128'(e.bo));
    chk({tag, "_zero"}, 128'(z), 128'(e.z));
    chk({tag, "_latency"}, 128'(cyc - e.acc), 128'(n));
  endtask

  // Monitors: compare on the rising edge of o_out_valid, sampled on the falling clock edge.
  logic pva = 1'b0, pvb = 1'b0, pvc = 1'b0;
  always @(negedge clk) begin
    if (ova && !pva) begin
      if (qa.size() == 0) fail_now("a_unexpected_result");
      else cmp_res("a", {120'b0, da}, boa, za, qa.pop_front(), 8);
    end
    pva <= ova;
  end
  always @(negedge clk) begin
    if (ovb && !pvb) begin
      if (qb.size() == 0) fail_now("b_unexpected_result");
      else cmp_res("b", {120'b0, db}, bob, zb, qb.pop_front(), 4);
    end
    pvb <= ovb;
  end
  always @(negedge clk) begin
    if (ovc && !pvc) begin
      c_results++;
      if (qc.size() == 0) fail_now("c_unexpected_result");
      else cmp_res("c", dc, boc, zc, qc.pop_front(), 128);
    end
    pvc <= ovc;
  end

  task automatic issue_a(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [7:0] ed, input logic ebo, input logic ez);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!ra && t < 300) begin @(negedge clk); t++; end
    if (!ra) begin fail_now("a_in_ready_timeout"); return; end
    a_a = a; b_a = b; bin_a = bin; va = 1'b1;
    e.d = {120'b0, ed}; e.bo = ebo; e.z = ez; e.acc = cyc + 1;
    qa.push_back(e);
    @(posedge clk);
    #1 va = 1'b0;
  endtask

  task automatic issue_b(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [7:0] ed, input logic ebo, input logic ez);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!rb && t < 300) begin @(negedge clk); t++; end
    if (!rb) begin fail_now("b_in_ready_timeout"); return; end
    a_b = a; b_b = b; bin_b = bin; vb = 1'b1;
    e.d = {120'b0, ed}; e.bo = ebo; e.z = ez; e.acc = cyc + 1;
    qb.push_back(e);
    @(posedge clk);
    #1 vb = 1'b0;
  endtask

  task automatic issue_c(input logic [127:0] a, input logic [127:0] b, input logic bin,
                         input logic [127:0] ed, input logic ebo, input logic ez);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!rc && t < 300) begin @(negedge clk); t++; end
    if (!rc) begin fail_now("c_in_ready_timeout"); return; end
    a_c = a; b_c = b; bin_c = bin; vc = 1'b1;
    e.d = ed; e.bo = ebo; e.z = ez; e.acc = cyc + 1;
    qc.push_back(e);
    @(posedge clk);
    #1 vc = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 400) begin @(negedge clk); t++; end
    if ((qa.size() + qb.size() + qc.size()) != 0) fail_now({nm, "_drain_timeout"});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ra_v, rb_v;
    logic         rbin;
    logic [128:0] full;
    int t;

    // Reset state
    #12;
    chk("rst_a_in_ready", 128'(ra), 0);
    chk("rst_a_out_valid", 128'(ova), 0);
    chk("rst_a_diff", 128'(da), 0);
    chk("rst_a_bout_zero", {boa, za}, 0);
    chk("rst_c_in_ready", 128'(rc), 0);
    chk("rst_c_diff", dc, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("a_in_ready_before_edge", 128'(ra), 0);
    @(negedge clk);
    chk("a_in_ready_after_edge", 128'(ra), 1);
    chk("b_in_ready_after_edge", 128'(rb), 1);

    // A: basic subtract; new operands waved during RUN must be ignored
    issue_a(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    a_a = 8'hFF; b_a = 8'h00; bin_a = 1'b1; va = 1'b1;
    repeat (4) @(negedge clk);
    chk("a_in_ready_run", 128'(ra), 0);
    va = 1'b0;
    drain("a_basic");

    // A: backpressure
    ora = 1'b0;
    issue_a(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);
    t = 0;
    while (!ova && t < 50) begin @(negedge clk); t++; end
    if (!ova) fail_now("a_bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("a_bp_diff", 128'(da), 128'h7F);
      chk("a_bp_out_valid", 128'(ova), 1);
      chk("a_bp_in_ready", 128'(ra), 0);
      va = i[0]; a_a = 8'($urandom); b_a = 8'($urandom);
    end
    va = 1'b0;
    @(negedge clk);
    ora = 1'b1;
    @(negedge clk);
    chk("a_release_in_ready", 128'(ra), 1);
    chk("a_release_out_valid", 128'(ova), 0);
    chk("a_idle_diff_held", 128'(da), 128'h7F);
    drain("a_bp");

    // A: reset during RUN
    issue_a(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("a_abort_out_valid", 128'(ova), 0);
    chk("a_abort_diff", 128'(da), 0);
    chk("a_abort_in_ready", 128'(ra), 0);
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("a_post_abort_in_ready", 128'(ra), 1);
    issue_a(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    drain("a_abort");

    // B: DIGIT=2 vectors
    issue_b(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    issue_b(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1);
    issue_b(8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain("b");

    // C: full width, wrap-around then random back-to-back
    issue_c(128'h0, 128'h1, 1'b0, {128{1'b1}}, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      ra_v = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb_v = (i % 17 == 0) ? ra_v : {$urandom(), $urandom(), $urandom(), $urandom()};
      rbin = 1'($urandom());
      full = {1'b0, ra_v} - {1'b0, rb_v} - 129'(rbin);
      issue_c(ra_v, rb_v, rbin, full[127:0], full[128], full[127:0] == '0);
    end
    drain("c");
    chk("c_result_count", 128'(c_results), 128'd201);
    chk("queues_empty", 128'(qa.size() + qb.size() + qc.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
